// File: rtl/sha_pkg.sv
// Shared types and default sizes for the SHA message-schedule datapath.
package sha_pkg;

  localparam int WORD_W      = 32;
  localparam int SCHED_DEPTH = 16;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    SHIFT  = 2'b01,
    LOAD   = 2'b10,
    ROTATE = 2'b11
  } sha_mode_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_FILL  = 2'b01,
    S_FULL  = 2'b10
  } win_state_e;

endpackage

// File: rtl/sha_word_reg.sv
// One window entry: async-reset register with sync clear and enable; next value
// is selected from the shift, load or rotate source by the current mode.
module sha_word_reg
  import sha_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  sha_mode_e        i_mode,
  input  logic [WIDTH-1:0] i_shift_src,
  input  logic [WIDTH-1:0] i_load_src,
  input  logic [WIDTH-1:0] i_rot_src,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;

  always_comb begin
    w_nxt = r_q;
    case (i_mode)
      SHIFT:   w_nxt = i_shift_src;
      LOAD:    w_nxt = i_load_src;
      ROTATE:  w_nxt = i_rot_src;
      default: w_nxt = r_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= w_nxt;
  end

  assign o_q = r_q;

endmodule

// File: rtl/sha_word_window.sv
// Sliding window of DEPTH words (entry 0 newest) with shift/load/rotate/hold,
// valid/ready input handshake and a registered fill count.
module sha_word_window
  import sha_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = SCHED_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [WIDTH-1:0]       i_in_data,
  input  logic [WIDTH*DEPTH-1:0] i_blk,
  output logic [WIDTH*DEPTH-1:0] o_data,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  sha_mode_e        w_mode;
  win_state_e       r_state;
  win_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             w_count_full;
  logic             w_shift_acc;
  logic             w_load_acc;
  logic             w_rot_act;
  logic             w_en;
  logic [WIDTH-1:0] w_entry [DEPTH];

  assign w_mode       = sha_mode_e'(i_mode);
  assign w_count_full = (r_count == CNT_W'(DEPTH));

  assign o_in_ready  = i_rst_n & ~i_start & ((w_mode == SHIFT) | (w_mode == LOAD));
  assign w_shift_acc = i_in_valid & o_in_ready & (w_mode == SHIFT);
  assign w_load_acc  = i_in_valid & o_in_ready & (w_mode == LOAD);
  // Rotate only makes sense on a complete window; otherwise it is a no-op.
  assign w_rot_act   = ~i_start & (w_mode == ROTATE) & w_count_full;
  assign w_en        = w_shift_acc | w_load_acc | w_rot_act;

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    logic [WIDTH-1:0] w_shift_src;
    logic [WIDTH-1:0] w_rot_src;
    if (k == 0) begin : g_head
      assign w_shift_src = i_in_data;
      assign w_rot_src   = w_entry[DEPTH-1];
    end else begin : g_body
      assign w_shift_src = w_entry[k-1];
      assign w_rot_src   = w_entry[k-1];
    end

    sha_word_reg #(.WIDTH(WIDTH)) u_word (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (i_start),
      .i_en        (w_en),
      .i_mode      (w_mode),
      .i_shift_src (w_shift_src),
      .i_load_src  (i_blk[k*WIDTH +: WIDTH]),
      .i_rot_src   (w_rot_src),
      .o_q         (w_entry[k])
    );

    assign o_data[k*WIDTH +: WIDTH] = w_entry[k];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         r_count <= '0;
    else if (i_start)                     r_count <= '0;
    else if (w_load_acc)                  r_count <= CNT_W'(DEPTH);
    else if (w_shift_acc && !w_count_full) r_count <= r_count + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = S_EMPTY;
    end else if (w_load_acc) begin
      w_state_nxt = S_FULL;
    end else if (w_shift_acc) begin
      if (r_count >= CNT_W'(DEPTH - 1)) w_state_nxt = S_FULL;
      else if (r_state == S_EMPTY)      w_state_nxt = S_FILL;
    end
  end

  assign o_count = r_count;
  assign o_full  = w_count_full;
  assign o_empty = (r_count == '0);

endmodule

// File: tb/tb_sha_word_window.sv
// Directed self-checking bench for sha_word_window at WIDTH=32, DEPTH=16.
module tb_sha_word_window;
  import sha_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int DW    = WIDTH * DEPTH;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic [1:0]       i_mode;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH-1:0] i_in_data;
  logic [DW-1:0]    i_blk;
  logic [DW-1:0]    o_data;
  logic [CNT_W-1:0] o_count;
  logic             o_full;
  logic             o_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_data;
  logic [DW-1:0] blk_ref;

  always #5 i_clk = ~i_clk;

  sha_word_window #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .i_blk      (i_blk),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] mode, input logic vld, input logic [WIDTH-1:0] d);
    i_mode     = mode;
    i_in_valid = vld;
    i_in_data  = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    step(HOLD, 1'b0, '0);
    i_start = 1'b0;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_mode     = HOLD;
    i_in_valid = 1'b0;
    i_in_data  = '0;
    i_blk      = '0;
    for (int k = 0; k < DEPTH; k++) blk_ref[k*WIDTH +: WIDTH] = 32'hA5A5_0000 + 32'(k);

    // reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      i_start    = 1'($urandom);
      i_blk      = {16{$urandom}};
      step(2'($urandom), 1'($urandom), $urandom);
      chk("rst_data", o_data, '0);
      chk("rst_count", DW'(o_count), '0);
      chk("rst_empty", DW'(o_empty), 1);
      chk("rst_ready", DW'(o_in_ready), 0);
    end
    chk("rst_state", DW'(dut.r_state), DW'(S_EMPTY));
    i_start = 1'b0;
    i_blk   = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // serial fill 1..16
    for (int i = 1; i <= DEPTH; i++) begin
      step(SHIFT, 1'b1, 32'(i));
      chk("fill_count", DW'(o_count), DW'(i));
      if (i == 1) chk("fill_state1", DW'(dut.r_state), DW'(S_FILL));
    end
    for (int k = 0; k < DEPTH; k++) exp_data[k*WIDTH +: WIDTH] = 32'(16 - k);
    chk("fill_data", o_data, exp_data);
    chk("fill_full", DW'(o_full), 1);
    chk("fill_state", DW'(dut.r_state), DW'(S_FULL));
    step(SHIFT, 1'b1, 32'h11);
    for (int k = 0; k < DEPTH; k++) exp_data[k*WIDTH +: WIDTH] = 32'(17 - k);
    chk("slide_data", o_data, exp_data);
    chk("slide_e15", DW'(o_data[15*WIDTH +: WIDTH]), 32'h2);
    chk("slide_count", DW'(o_count), 16);

    // start with a concurrent shift: input dropped, bank clears
    i_start = 1'b1;
    i_mode = SHIFT; i_in_valid = 1'b1; i_in_data = 32'hDEAD_BEEF;
    #1;
    chk("start_ready", DW'(o_in_ready), 0);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    chk("start_data", o_data, '0);
    chk("start_count", DW'(o_count), 0);
    chk("start_empty", DW'(o_empty), 1);
    chk("start_state", DW'(dut.r_state), DW'(S_EMPTY));

    // partial fill to 5, then HOLD with valid must not change anything
    for (int i = 1; i <= 5; i++) step(SHIFT, 1'b1, 32'(i));
    exp_data = '0;
    for (int k = 0; k < 5; k++) exp_data[k*WIDTH +: WIDTH] = 32'(5 - k);
    step(HOLD, 1'b1, 32'hCAFE_F00D);
    chk("hold_data", o_data, exp_data);
    chk("hold_count", DW'(o_count), 5);
    step(SHIFT, 1'b0, 32'hCAFE_F00D);
    chk("novalid_data", o_data, exp_data);

    // block load from count 5
    i_blk = blk_ref;
    step(LOAD, 1'b1, '0);
    i_blk = '0;
    chk("load_data", o_data, blk_ref);
    chk("load_count", DW'(o_count), 16);
    chk("load_full", DW'(o_full), 1);
    chk("load_state", DW'(dut.r_state), DW'(S_FULL));

    // rotate
    step(ROTATE, 1'b1, 32'hFFFF_FFFF);
    chk("rot1_e0", DW'(o_data[0 +: WIDTH]), 32'hA5A5_000F);
    chk("rot1_e1", DW'(o_data[WIDTH +: WIDTH]), 32'hA5A5_0000);
    chk("rot1_e15", DW'(o_data[15*WIDTH +: WIDTH]), 32'hA5A5_000E);
    for (int r = 1; r < DEPTH; r++) step(ROTATE, 1'b0, '0);
    chk("rot16_data", o_data, blk_ref);
    chk("rot16_count", DW'(o_count), 16);

    // rotate while count=3 is a no-op
    do_start();
    for (int i = 1; i <= 3; i++) step(SHIFT, 1'b1, 32'(i));
    exp_data = '0;
    exp_data[0 +: WIDTH]       = 32'h3;
    exp_data[WIDTH +: WIDTH]   = 32'h2;
    exp_data[2*WIDTH +: WIDTH] = 32'h1;
    step(ROTATE, 1'b0, '0);
    chk("rot_nf_data", o_data, exp_data);
    chk("rot_nf_count", DW'(o_count), 3);

    // async reset between edges at count 9
    do_start();
    for (int i = 1; i <= 9; i++) step(SHIFT, 1'b1, 32'(i + 32'h100));
    chk("pre_arst_count", DW'(o_count), 9);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_data", o_data, '0);
    chk("arst_count", DW'(o_count), 0);
    chk("arst_empty", DW'(o_empty), 1);
    chk("arst_ready", DW'(o_in_ready), 0);
    chk("arst_state", DW'(dut.r_state), DW'(S_EMPTY));
    #2;
    i_rst_n = 1'b1;
    step(SHIFT, 1'b1, 32'h77);
    chk("post_arst_count", DW'(o_count), 1);
    chk("post_arst_e0", DW'(o_data[0 +: WIDTH]), 32'h77);
    chk("post_arst_state", DW'(dut.r_state), DW'(S_FILL));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_word_window.md
# sha_word_window

Parametrised multi-word register bank for the SHA datapath. It holds a sliding window of DEPTH words of WIDTH bits, used as the message-schedule window W[t-1..t-16]. It supports four operations: serial shift-in, whole-block parallel load, rotate and hold, with a valid/ready input handshake and fill tracking. It sits between the padded-block input stage and the schedule/compression logic, and generalises the single-word load-enable register.

## Interface
- WIDTH, 32, bits per word
- DEPTH, 16, number of words (≥2)
- CNT_W, $clog2(DEPTH+1), width of fill count
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset; low clears all state immediately
- start  in  1  synchronous clear; highest priority after RST
- mode  in  2  00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE
- in_valid  in  1  input word/block valid
- in_ready  out  1  bank accepts input this cycle
- in_data  in  WIDTH  word for SHIFT
- blk_i  in  WIDTH*DEPTH  block for LOAD; word k = blk_i[k*WIDTH +: WIDTH]
- data_o  out  WIDTH*DEPTH  all entries; entry k = data_o[k*WIDTH +: WIDTH], entry 0 newest
- count_o  out  CNT_W  valid words held, 0..DEPTH
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0

## Operation
- Combinational `in_ready` = RST & ~start & (mode==SHIFT | mode==LOAD). Accept = in_valid & in_ready.
- Priority per edge: RST low > start > mode action.
- start: all entries ← 0, count ← 0, state → S_EMPTY.
- SHIFT accept: entry 0 ← in_data, entry k ← entry k-1 for k=1..DEPTH-1, old entry DEPTH-1 discarded. Count increments and saturates at DEPTH. The shift is also accepted when full (sliding window).
- LOAD accept: every entry ← corresponding blk_i word, count ← DEPTH, from any state.
- ROTATE (no handshake, in_ready=0): only when full. Entry 0 ← entry DEPTH-1, entry k ← entry k-1. Count unchanged. When not full it is a no-op.
- HOLD, or SHIFT/LOAD without in_valid: no change.
- FSM states and transitions:
  - S_EMPTY → S_FILL on a SHIFT accept when DEPTH>1.
  - S_EMPTY or S_FILL → S_FULL on a LOAD accept, or when a SHIFT accept brings count to DEPTH.
  - Any state → S_EMPTY on start.
  - S_FULL stays in S_FULL on SHIFT or ROTATE.
- full_o and empty_o are decoded from registered count, not from state. State and count must stay consistent; the bench asserts this.

## Timing
- Reset values: data_o all 0, count_o 0, full_o 0, empty_o 1, in_ready 0, state S_EMPTY.
- Latency 1: an accept or rotate at edge N is visible on data_o/count_o after edge N. No combinational path from in_data or blk_i to data_o.
- in_ready depends only on RST, start and mode, never on in_valid.
- RST asserted mid-fill or mid-rotate clears everything asynchronously. The first accept is possible on the first edge with RST high.
- start and in_valid in the same cycle: the input is dropped (in_ready=0) and the bank clears.
- Mode changes take effect on the cycle they are presented. No pipelined mode.

## Structure
- Shared package `sha_pkg` contents:
  - `sha_mode_e` (HOLD/SHIFT/LOAD/ROTATE)
  - `win_state_e` (S_EMPTY/S_FILL/S_FULL)
  - default localparams WORD_W=32, SCHED_DEPTH=16
- Sub-module `sha_word_reg`: one WIDTH-bit register with async active-low RST, synchronous clear and load enable, next value muxed from SHIFT/LOAD/ROTATE sources. The bank instantiates it DEPTH times via generate. Control (count, FSM, in_ready) lives in the top.

## Test plan
- Reset: hold RST low 3 cycles with random inputs → data_o=0, count_o=0, empty_o=1, in_ready=0 throughout.
- Serial fill, WIDTH=32/DEPTH=16: SHIFT words 0x00000001..0x00000010 with in_valid=1 → count increments each cycle; after the 16th, full_o=1, entry 0=0x10, entry 15=0x01. A 17th word 0x11 → entry 15=0x02, count stays 16.
- Block load: LOAD with blk_i word k = 0xA5A50000+k, from a partially filled state (count=5) → next cycle entry k matches, count=16, full_o=1.
- Rotate: after the block load, ROTATE 16 cycles → data_o returns to the original. After 1 cycle, entry 0=0xA5A5000F. ROTATE while count=3 → no change.
- Handshake/priority: start=1 with SHIFT and in_valid=1, in_data=0xDEADBEEF → in_ready=0, bank cleared, word not stored. HOLD with in_valid=1 → no change.
- Async reset mid-operation: drop RST between edges during a fill at count=9 → outputs go to reset values before the next edge; fill restarts from count 0.
